// File: rtl/refresh_rng.sv
// refresh_rng: seeded 32-bit Fibonacci LFSR that supplies OUT_BITS refresh bits per beat to a masked AND gadget.
// Define REFRESH_RNG_RESEED_LIMIT_EN to force a reseed after RESEED_LIMIT consumed beats.
module refresh_rng #(
    parameter int OUT_BITS      = 3,
    parameter int WARMUP_CYCLES = 64,
    parameter int RESEED_LIMIT  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         seed,
    input  logic                seed_valid,
    output logic                seed_ready,
    output logic                seed_err,
    output logic [OUT_BITS-1:0] r,
    output logic                r_valid,
    input  logic                r_ready,
    output logic                reseed_req
);

    localparam int CW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {UNSEEDED, WARMUP, RUN} state_t;

    state_t        state, state_d;
    logic [31:0]   lfsr, lfsr_d, lfsr_adv;
    logic [CW-1:0] counter, counter_d;
    logic          valid_d, err_d;
    logic          seed_take, seed_load, seed_zero;

    // One advance is OUT_BITS single steps, unrolled.
    function automatic logic [31:0] advance(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < OUT_BITS; i++)
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        return t;
    endfunction

    assign seed_ready = ~reset;
    assign seed_take  = seed_valid & seed_ready;
    assign seed_load  = seed_take & (seed != 32'd0);
    assign seed_zero  = seed_take & (seed == 32'd0);
    assign lfsr_adv   = advance(lfsr);

`ifdef REFRESH_RNG_RESEED_LIMIT_EN
    localparam int UW = (RESEED_LIMIT > 1) ? $clog2(RESEED_LIMIT) : 1;
    localparam logic [UW-1:0] USE_LAST = UW'(RESEED_LIMIT - 1);
    logic [UW-1:0] use_cnt, use_d;
    logic          req_q, req_d;
    assign reseed_req = req_q;
`else
    assign reseed_req = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        lfsr_d    = lfsr;
        counter_d = counter;
        valid_d   = r_valid;
        err_d     = seed_err;
`ifdef REFRESH_RNG_RESEED_LIMIT_EN
        use_d     = use_cnt;
        req_d     = req_q;
`endif
        if (seed_load) begin
            // A good seed wins over everything, including a beat offered this cycle.
            state_d   = WARMUP;
            lfsr_d    = seed;
            counter_d = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
`ifdef REFRESH_RNG_RESEED_LIMIT_EN
            use_d     = '0;
            req_d     = 1'b0;
`endif
        end else begin
            // A rejected zero seed only raises the flag; the stream is not disturbed.
            if (seed_zero)
                err_d = 1'b1;
            case (state)
                WARMUP: begin
                    lfsr_d    = lfsr_adv;
                    counter_d = counter + 1'b1;
                    if (counter == WARM_LAST) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end
                end
                RUN: begin
                    if (r_ready) begin
                        lfsr_d = lfsr_adv;
`ifdef REFRESH_RNG_RESEED_LIMIT_EN
                        if (use_cnt == USE_LAST) begin
                            state_d = UNSEEDED;
                            valid_d = 1'b0;
                            req_d   = 1'b1;
                        end else begin
                            use_d = use_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= UNSEEDED;
            lfsr     <= '0;
            counter  <= '0;
            r_valid  <= 1'b0;
            seed_err <= 1'b0;
            r        <= '0;
        end else begin
            state    <= state_d;
            lfsr     <= lfsr_d;
            counter  <= counter_d;
            r_valid  <= valid_d;
            seed_err <= err_d;
            // r is its own register so it stays glitch-free and independent of r_ready.
            r        <= valid_d ? lfsr_d[OUT_BITS-1:0] : '0;
        end
    end

`ifdef REFRESH_RNG_RESEED_LIMIT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            use_cnt <= '0;
            req_q   <= 1'b0;
        end else begin
            use_cnt <= use_d;
            req_q   <= req_d;
        end
    end
`endif

endmodule

// File: tb/tb_refresh_rng.sv
// Bench for refresh_rng: random consumer back-pressure, scoreboard queue filled from a software LFSR model.
module tb_refresh_rng;

    localparam int OB  = 3;
    localparam int W   = 64;
    localparam int LIM = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   seed = '0;
    logic          seed_valid = 1'b0;
    logic          seed_ready;
    logic          seed_err;
    logic [OB-1:0] r;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic          reseed_req;

    int tests = 0;
    int fails = 0;

    logic [31:0] sb[$];
    logic        stall_chk = 1'b0;
    logic [OB-1:0] stall_r = '0;

    refresh_rng #(.OUT_BITS(OB), .WARMUP_CYCLES(W), .RESEED_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset), .seed(seed), .seed_valid(seed_valid),
        .seed_ready(seed_ready), .seed_err(seed_err), .r(r), .r_valid(r_valid),
        .r_ready(r_ready), .reseed_req(reseed_req)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Expected beats for a seed: skip W*OB bits of warm-up, then OB bits per beat.
    task automatic load_model(input logic [31:0] s0);
        logic [31:0] s;
        s = s0;
        sb.delete();
        for (int i = 0; i < W * OB; i++) s = lstep(s);
        for (int b = 0; b < 80; b++) begin
            sb.push_back({29'd0, s[OB-1:0]});
            for (int i = 0; i < OB; i++) s = lstep(s);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_seed(input logic [31:0] s);
        seed = s;
        seed_valid = 1'b1;
        if (s != 32'd0) load_model(s);
        step();
        seed_valid = 1'b0;
        seed = $urandom;
    endtask

    // Seed with r_ready high, then confirm first valid beat lands exactly W edges later.
    task automatic seed_and_warm(input logic [31:0] s, input string tag);
        r_ready = 1'b1;
        send_seed(s);
        chk({tag, "_valid_drop"}, {31'd0, r_valid}, 32'd0);
        chk({tag, "_err_clear"}, {31'd0, seed_err}, 32'd0);
        chk({tag, "_req_clear"}, {31'd0, reseed_req}, 32'd0);
        for (int i = 0; i < W - 1; i++) begin
            r_ready = 1'($urandom);
            step();
        end
        chk({tag, "_valid_before_w"}, {31'd0, r_valid}, 32'd0);
        step();
        chk({tag, "_valid_at_w"}, {31'd0, r_valid}, 32'd1);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            r_ready = 1'($urandom);
            step();
        end
        r_ready = 1'b0;
    endtask

    // Monitor: every beat the consumer takes is compared against the scoreboard head.
    always @(negedge clock) begin
        if (reset) begin
            stall_chk <= 1'b0;
        end else begin
            if (stall_chk) begin
                chk("stall_valid_hold", {31'd0, r_valid}, 32'd1);
                chk("stall_r_hold", {29'd0, r}, {29'd0, stall_r});
            end
            if (!r_valid) chk("r_zero_when_invalid", {29'd0, r}, 32'd0);
            if (r_valid && r_ready && !(seed_valid && seed != 32'd0)) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: beat 0x%0h with no expected value", r);
                end else begin
                    chk("r_beat", {29'd0, r}, sb.pop_front());
                end
            end
            stall_chk <= r_valid && !r_ready && !(seed_valid && seed != 32'd0);
            stall_r   <= r;
        end
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
        chk("rst_r", {29'd0, r}, 32'd0);
        chk("rst_seed_err", {31'd0, seed_err}, 32'd0);
        chk("rst_seed_ready", {31'd0, seed_ready}, 32'd1);
        chk("rst_reseed_req", {31'd0, reseed_req}, 32'd0);

        // Zero seed while unseeded: flagged, nothing starts.
        send_seed(32'd0);
        chk("zero_seed_err", {31'd0, seed_err}, 32'd1);
        repeat (W + 5) step();
        chk("zero_seed_no_valid", {31'd0, r_valid}, 32'd0);

        seed_and_warm(32'hACE10001, "s1");
        // Consume two, stall five, then random back-pressure.
        r_ready = 1'b1;
        repeat (2) step();
        r_ready = 1'b0;
        repeat (5) step();
        run_random(40);
`ifdef REFRESH_RNG_RESEED_LIMIT_EN
        chk("limit_valid_low", {31'd0, r_valid}, 32'd0);
        chk("limit_reseed_req", {31'd0, reseed_req}, 32'd1);
`else
        chk("run_valid_held", {31'd0, r_valid}, 32'd1);
        chk("no_reseed_req", {31'd0, reseed_req}, 32'd0);
`endif

        seed_and_warm(32'h0BADBEEF, "s2");
        // Reseed while RUN with a beat on offer: that beat must be dropped.
        seed_and_warm(32'h12345678, "s3");
        run_random(30);

        // Async reset mid-warm-up with the error flag set.
        send_seed(32'hDEADBEEF);
        repeat (29) step();
        send_seed(32'd0);
        chk("warm_zero_err", {31'd0, seed_err}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_err", {31'd0, seed_err}, 32'd0);
        chk("async_rst_valid", {31'd0, r_valid}, 32'd0);
        chk("async_rst_seed_ready", {31'd0, seed_ready}, 32'd0);
        sb.delete();
        step();
        reset = 1'b0;

        // Async reset mid-run.
        seed_and_warm(32'h00000001, "s4");
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("run_rst_valid", {31'd0, r_valid}, 32'd0);
        chk("run_rst_r", {29'd0, r}, 32'd0);
        chk("run_rst_req", {31'd0, reseed_req}, 32'd0);
        sb.delete();
        step();
        reset = 1'b0;
        r_ready = 1'b1;
        repeat (W + 10) step();
        chk("post_rst_needs_seed", {31'd0, r_valid}, 32'd0);
        chk("post_rst_seed_ready", {31'd0, seed_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
